// File: rtl/lsu_pkg.sv
// Package: lsu_pkg
// Shared types and constants for the load/store unit.
//   lsu_state_e : access sequencer states (IDLE, ACCESS, RESP)
//   OP_LOAD / OP_STORE : encoding of the request's store bit
//   ZERO_REG    : hard-wired zero register (XZR), never written back
//   sat_inc32   : saturating 32-bit increment used by the optional statistics
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam logic       OP_LOAD  = 1'b0;
  localparam logic       OP_STORE = 1'b1;
  localparam logic [4:0] ZERO_REG = 5'd31;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lsu_wait_counter.sv
// Module: lsu_wait_counter
// Loadable down-counter that times how long the memory strobes are held.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_load       : load i_load_val (has priority over decrement)
//   i_load_val   : value to load
//   i_dec        : decrement by one; stops at zero
//   o_zero       : count is zero
module lsu_wait_counter #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [CW-1:0] r_count;

  // Count register: load, else decrement towards zero, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= {CW{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != {CW{1'b0}})) begin
      r_count <= r_count - CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == {CW{1'b0}});

endmodule

// File: rtl/load_store_unit.sv
// Module: load_store_unit
// Memory-access initiator between the execute stage and a word-addressed
// data memory. One load/store is accepted per valid/ready handshake; the
// read/write strobe is held for MEM_LATENCY cycles, then a single response
// cycle reports done/err and, for loads, writes back through the register
// file port. Out-of-range addresses skip the memory and respond at once.
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   req_valid/req_ready              : request handshake (ready only in IDLE)
//   req_store, req_addr, req_wdata,
//   req_rd                           : request payload
//   mem_addr, mem_wdata, mem_read,
//   mem_write, mem_rdata             : data memory interface
//   wb_en, wb_reg, wb_data           : register-file write port (pulse)
//   done, err                        : completion pulse and range error
// Optional feature macro LSU_STATS_EN adds saturating 32-bit counters
//   ld_count, st_count, err_count.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int REG_AW      = 5,
  parameter int MEM_DEPTH   = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [REG_AW-1:0] req_rd,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic              err
`ifdef LSU_STATS_EN
  ,
  output logic [31:0]       ld_count,
  output logic [31:0]       st_count,
  output logic [31:0]       err_count
`endif
);

  localparam int                CW       = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0]     LAT_M1   = CW'(MEM_LATENCY - 1);
  localparam logic [DATA_W-1:0] DEPTH_V  = DATA_W'(MEM_DEPTH);
  localparam logic [REG_AW-1:0] XZR      = REG_AW'(ZERO_REG);

  lsu_state_e        r_state, w_state_nxt;
  logic              r_store, w_store_nxt;
  logic              r_err_flag, w_err_flag_nxt;
  logic [REG_AW-1:0] r_rd, w_rd_nxt;
  logic [DATA_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              r_mem_read, w_mem_read_nxt;
  logic              r_mem_write, w_mem_write_nxt;
  logic              r_wb_en, w_wb_en_nxt;
  logic [REG_AW-1:0] r_wb_reg, w_wb_reg_nxt;
  logic [DATA_W-1:0] r_wb_data, w_wb_data_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic              r_req_ready, w_ready_nxt;
  logic              w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic              w_in_range;

  // Unsigned compare over the full address width.
  assign w_in_range = (req_addr < DEPTH_V);

  lsu_wait_counter #(.CW(CW)) u_wait (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (LAT_M1),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt     = r_state;
    w_store_nxt     = r_store;
    w_err_flag_nxt  = r_err_flag;
    w_rd_nxt        = r_rd;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_read_nxt  = 1'b0;
    w_mem_write_nxt = 1'b0;
    w_wb_en_nxt     = 1'b0;
    w_wb_reg_nxt    = r_wb_reg;
    w_wb_data_nxt   = r_wb_data;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_ready_nxt     = r_req_ready;
    w_cnt_load      = 1'b0;
    w_cnt_dec       = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready_nxt = 1'b1;
        if (req_valid && r_req_ready) begin
          w_store_nxt    = req_store;
          w_rd_nxt       = req_rd;
          w_err_flag_nxt = ~w_in_range;
          w_ready_nxt    = 1'b0;
          if (w_in_range) begin
            w_state_nxt     = ACCESS;
            w_mem_addr_nxt  = req_addr;
            w_mem_wdata_nxt = req_wdata;
            w_mem_read_nxt  = (req_store == OP_LOAD);
            w_mem_write_nxt = (req_store == OP_STORE);
            w_cnt_load      = 1'b1;
          end else begin
            // Out of range: memory is never touched, respond next cycle.
            w_state_nxt = RESP;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCESS: begin
        w_ready_nxt = 1'b0;
        if (w_cnt_zero) begin
          // Last strobe cycle: mem_rdata is valid on this edge.
          w_state_nxt = RESP;
          w_done_nxt  = 1'b1;
          w_err_nxt   = r_err_flag;
          if ((r_store == OP_LOAD) && (r_rd != XZR)) begin
            w_wb_en_nxt   = 1'b1;
            w_wb_reg_nxt  = r_rd;
            w_wb_data_nxt = mem_rdata;
          end else begin
            w_wb_en_nxt = 1'b0;
          end
        end else begin
          w_mem_read_nxt  = r_mem_read;
          w_mem_write_nxt = r_mem_write;
          w_cnt_dec       = 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_store     <= OP_LOAD;
      r_err_flag  <= 1'b0;
      r_rd        <= {REG_AW{1'b0}};
      r_mem_addr  <= {DATA_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_wb_en     <= 1'b0;
      r_wb_reg    <= {REG_AW{1'b0}};
      r_wb_data   <= {DATA_W{1'b0}};
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_req_ready <= 1'b1;
    end else begin
      r_store     <= w_store_nxt;
      r_err_flag  <= w_err_flag_nxt;
      r_rd        <= w_rd_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_wb_en     <= w_wb_en_nxt;
      r_wb_reg    <= w_wb_reg_nxt;
      r_wb_data   <= w_wb_data_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_req_ready <= w_ready_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign wb_en     = r_wb_en;
  assign wb_reg    = r_wb_reg;
  assign wb_data   = r_wb_data;
  assign done      = r_done;
  assign err       = r_err;

`ifdef LSU_STATS_EN
  logic [31:0] r_ld_count, r_st_count, r_err_count;

  // Per-kind completion counters, updated on the edge that raises done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_count  <= 32'd0;
      r_st_count  <= 32'd0;
      r_err_count <= 32'd0;
    end else if (w_done_nxt) begin
      if (w_err_nxt) begin
        r_err_count <= sat_inc32(r_err_count);
      end else if (w_store_nxt == OP_STORE) begin
        r_st_count <= sat_inc32(r_st_count);
      end else begin
        r_ld_count <= sat_inc32(r_ld_count);
      end
    end else begin
      r_ld_count  <= r_ld_count;
      r_st_count  <= r_st_count;
      r_err_count <= r_err_count;
    end
  end

  assign ld_count  = r_ld_count;
  assign st_count  = r_st_count;
  assign err_count = r_err_count;
`endif

endmodule
